// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit serializer and its counters.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_GAP       = 0;
  localparam int DEF_MSB_FIRST = 1;

  // Smallest width (at least 1) that can represent max_val without wrapping.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module bit_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_count <= '0;
    else if (i_load)
      r_count <= i_load_val;
    else if (i_dec && (r_count != '0))
      r_count <= r_count - 1'b1;
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one word out per accept, optional zero gap after each word.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int GAP       = DEF_GAP,
  parameter int MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_w(WIDTH - 1);
  localparam int GL = (GAP > 0) ? GAP - 1 : 0;
  localparam int GW = cnt_w(GL);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GL);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_serial;
  logic             r_done;

  logic w_accept, w_bit_zero, w_gap_zero, w_last_bit;
  logic w_first_bit, w_next_bit;

  assign data_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept   = data_valid && data_ready;
  assign w_last_bit = (r_state == ST_SHIFT) && w_bit_zero;

  // The bit just loaded goes straight to serial_out, so the register only
  // ever needs to supply the neighbour of the bit currently on the line.
  assign w_first_bit = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
  assign w_next_bit  = (MSB_FIRST != 0) ? r_shift[WIDTH-2] : r_shift[1];

  bit_counter #(.W(BW)) u_bit_cnt (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_load     (w_accept),
    .i_load_val (BIT_LOAD),
    .i_dec      (r_state == ST_SHIFT),
    .o_zero     (w_bit_zero)
  );

  bit_counter #(.W(GW)) u_gap_cnt (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_load     (w_last_bit && (GAP > 0)),
    .i_load_val (GAP_LOAD),
    .i_dec      (r_state == ST_GAP),
    .o_zero     (w_gap_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_serial <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_serial <= 1'b0;
          if (w_accept) begin
            r_shift  <= data_in;
            r_serial <= w_first_bit;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_bit_zero) begin
            r_serial <= 1'b0;
            r_done   <= 1'b1;
            r_shift  <= '0;
            r_state  <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            r_serial <= w_next_bit;
            r_shift  <= (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
          end
        end
        ST_GAP: begin
          r_serial <= 1'b0;
          if (w_gap_zero)
            r_state <= ST_IDLE;
        end
        default: begin
          r_serial <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign serial_out = r_serial;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed plus randomized bench for bit_serializer across three parameter sets.
module tb_bit_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dv, rdy, so, bsy, dn;
  logic [7:0] din [3];

  int checks = 0;
  int errors = 0;
  int gaps [3];
  int msbf [3];

  always #5 clock = ~clock;

  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u_d0 (
    .clock(clock), .reset(reset), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .serial_out(so[0]), .busy(bsy[0]), .done(dn[0]));

  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) u_d1 (
    .clock(clock), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .serial_out(so[1]), .busy(bsy[1]), .done(dn[1]));

  bit_serializer #(.WIDTH(8), .GAP(3), .MSB_FIRST(1)) u_d2 (
    .clock(clock), .reset(reset), .data_in(din[2]), .data_valid(dv[2]),
    .data_ready(rdy[2]), .serial_out(so[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: the i-th transmitted bit is word bit (7-i) or bit i.
  function automatic logic model_bit(input int idx, input logic [7:0] w, input int i);
    int pos;
    pos = (msbf[idx] != 0) ? 7 - i : i;
    return logic'((w >> pos) & 8'd1);
  endfunction

  // Called in an idle cycle; returns in the next idle (ready) cycle.
  task automatic send(input int idx, input logic [7:0] word, input bit noise);
    din[idx] = word;
    dv[idx]  = 1'b1;
    chk($sformatf("d%0d_ready_pre", idx), rdy[idx], 1);
    step();
    dv[idx]  = 1'b0;
    din[idx] = ~word;
    for (int i = 0; i < 8; i++) begin
      if (noise) begin
        dv[idx]  = 1'b1;
        din[idx] = 8'($urandom);
      end
      chk($sformatf("d%0d_bit%0d", idx, i), so[idx], model_bit(idx, word, i));
      chk($sformatf("d%0d_busy%0d", idx, i), bsy[idx], 1);
      chk($sformatf("d%0d_rdy%0d", idx, i), rdy[idx], 0);
      chk($sformatf("d%0d_done%0d", idx, i), dn[idx], 0);
      step();
    end
    if (!noise) dv[idx] = 1'b0;
    for (int j = 0; j < gaps[idx]; j++) begin
      chk($sformatf("d%0d_gap_so%0d", idx, j), so[idx], 0);
      chk($sformatf("d%0d_gap_done%0d", idx, j), dn[idx], (j == 0) ? 1 : 0);
      chk($sformatf("d%0d_gap_rdy%0d", idx, j), rdy[idx], 0);
      chk($sformatf("d%0d_gap_busy%0d", idx, j), bsy[idx], 1);
      step();
    end
    dv[idx] = 1'b0;
    chk($sformatf("d%0d_end_so", idx), so[idx], 0);
    chk($sformatf("d%0d_end_rdy", idx), rdy[idx], 1);
    chk($sformatf("d%0d_end_busy", idx), bsy[idx], 0);
    chk($sformatf("d%0d_end_done", idx), dn[idx], (gaps[idx] == 0) ? 1 : 0);
  endtask

  initial begin
    gaps[0] = 0; gaps[1] = 0; gaps[2] = 3;
    msbf[0] = 1; msbf[1] = 0; msbf[2] = 1;
    dv = '0;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;

    // Held in reset: everything quiet, not ready.
    step();
    step();
    chk("rst_so", 32'(so), 0);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_done", 32'(dn), 0);
    chk("rst_rdy", 32'(rdy), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(rdy), 32'h7);

    send(0, 8'b10010010, 1'b0);
    send(1, 8'hB4, 1'b0);
    send(2, 8'h81, 1'b1);
    send(2, 8'h3C, 1'b1);
    send(0, 8'h5A, 1'b1);

    // Reset in the middle of bit 4 of a word.
    din[0] = 8'hFF;
    dv[0]  = 1'b1;
    step();
    dv[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_mid_rst_busy", bsy[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_so", so[0], 0);
    chk("mid_rst_busy", bsy[0], 0);
    chk("mid_rst_done", dn[0], 0);
    chk("mid_rst_rdy", rdy[0], 0);
    step();
    reset = 1'b0;
    #1;
    chk("after_rst_rdy", rdy[0], 1);
    chk("after_rst_done", dn[0], 0);
    step();
    chk("after_rst_done2", dn[0], 0);
    chk("after_rst_so", so[0], 0);
    send(0, 8'h92, 1'b0);

    for (int n = 0; n < 8; n++)
      for (int idx = 0; idx < 3; idx++)
        send(idx, 8'($urandom), bit'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
